commit_unit: RTL and testbench
==============================

# commit_unit

In-order retirement engine for the 32-entry speculative temporary register file. It reads the oldest entry through one temp-file read port and retires it once its speculative result is valid. Register results go to the architectural register file; stores are retired through a request/acknowledge handshake with the data memory. It owns the head pointer and occupancy count, and sits between regfiletmp and the architectural register file / store path.

## Interface
- DEPTH, 32: temp-file entries; must be a power of two.
- ENTRY_W, 73: entry width. Layout: rd_reg[72:68], PC[67:36], Inst_type[35:34], spec_data[33:2], spec_valid[1], valid[0].
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low.
- flush  in  1  synchronous squash of all in-flight state.
- alloc  in  1  pulse: dispatch wrote a new entry at the tail; same signal as regfiletmp New_entry.
- Rd_Addr  out  5  temp-file read address; always equals head.
- Data_In  in  73  combinational temp-file read data for Rd_Addr.
- arf_we  out  1  architectural register write enable.
- arf_waddr  out  5  architectural register address, from rd_reg.
- arf_wdata  out  32  write data, from spec_data.
- st_req  out  1  store retire request.
- st_ack  in  1  store accepted.
- commit_valid  out  1  one-cycle pulse per retired entry.
- commit_pc  out  32  PC of the retired entry.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: alloc arrived while full.

## Operation
- Instruction types (Inst_type):
  - 00 ALU: writes a register.
  - 01 LOAD: writes a register.
  - 10 STORE: no register write; retires via the store handshake.
  - 11 BRANCH: no register write.
- A head entry is ready when: not empty, Data_In[0] = 1 and Data_In[1] = 1.
- FSM states: IDLE, STORE_WAIT.
- IDLE, ready, type ≠ STORE:
  - Retire: head increments modulo DEPTH, count decrements.
  - Next cycle, commit_valid = 1 and commit_pc = PC.
  - Next cycle, arf_we = 1 for ALU/LOAD only, with arf_waddr and arf_wdata as above.
  - arf_we is suppressed when rd_reg = 0 (r0 is hardwired).
- IDLE, ready, type = STORE: go to STORE_WAIT; st_req is registered high the next cycle.
- STORE_WAIT:
  - st_req held high until st_ack is sampled high.
  - On st_ack: retire the entry (head++, count--, commit_valid next cycle), drop st_req, return to IDLE.
  - st_ack outside STORE_WAIT is ignored.
- Throughput: at most one retirement per cycle. A store costs at least 2 cycles.
- Occupancy:
  - alloc and retire in the same cycle: count unchanged.
  - alloc while full: ignored, overflow set.
  - Retire is never attempted while empty.
- Head pointer wraps from 31 to 0.
- Flush:
  - Clears head, count, FSM state (→ IDLE), st_req, arf_we and commit_valid.
  - A coincident st_ack or alloc is discarded.
  - overflow is preserved (cleared only by reset).
- Reset (active-low, synchronous): every output 0 except empty = 1; Rd_Addr = 0.

## Timing
- Retirement decision is combinational on Data_In in the same cycle Rd_Addr = head; all outputs are registered.
- Latency from ready head to commit_valid / arf_we: 1 cycle.
- Store path: STORE decision at cycle t, st_req high from t+1, st_ack sampled at cycle k ≥ t+1, commit_valid at k+1.
- reset takes priority over flush; flush takes priority over all other inputs.

## Configuration
- COMMIT_STATS_EN:
  - Defined: adds output retired_cnt (32 bits). It increments on every commit_valid, wraps at 2^32, and is cleared by reset only, not by flush.
  - Undefined: the port and counter are absent.

## Structure
- Shared package holds:
  - Entry field bit positions and ENTRY_W.
  - Inst_type encodings (ALU, LOAD, STORE, BRANCH).
  - FSM state encoding.
  - DEPTH.
- Natural sub-module: commit_ptr, the head pointer plus occupancy counter with full/empty/overflow logic; it is shared with the dispatch-side tail logic.

## Test plan
- Reset then 3 allocs; head entries ALU r5 = 0x11, LOAD r6 = 0x22, BRANCH, all valid -> arf_we on 3 consecutive... ALU and LOAD write r5 = 0x11 then r6 = 0x22; BRANCH gives commit_valid with no arf_we; empty = 1 after.
- Head ALU r7, valid = 1, spec_valid = 0 for 4 cycles, then 1 -> no retirement for 4 cycles; retire 1 cycle after spec_valid rises.
- STORE at head, st_ack delayed 3 cycles -> st_req high 3 cycles, commit_valid the cycle after ack, head + 1.
- 32 allocs, a 33rd alloc, then 32 retires -> full = 1, overflow = 1, head wraps 31 → 0, empty = 1 at end.
- Flush in STORE_WAIT with simultaneous st_ack -> st_req = 0, no commit_valid, head = 0, count = 0.
- ALU r0 = 0x5 -> commit_valid = 1, arf_we = 0; with COMMIT_STATS_EN defined, retired_cnt increments by 1.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared definitions for the commit unit: temp-file entry layout, instruction types, FSM states.
// Also used by the dispatch-side tail logic that shares commit_ptr.
package commit_unit_pkg;
  localparam int DEPTH   = 32;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 73;

  localparam int RD_HI   = 72;
  localparam int RD_LO   = 68;
  localparam int PC_HI   = 67;
  localparam int PC_LO   = 36;
  localparam int TYPE_HI = 35;
  localparam int TYPE_LO = 34;
  localparam int DATA_HI = 33;
  localparam int DATA_LO = 2;
  localparam int SPEC_VLD_BIT = 1;
  localparam int VLD_BIT      = 0;

  typedef enum logic [1:0] {
    IT_ALU    = 2'b00,
    IT_LOAD   = 2'b01,
    IT_STORE  = 2'b10,
    IT_BRANCH = 2'b11
  } inst_type_e;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_STORE_WAIT = 1'b1
  } state_e;

  function automatic logic writes_reg(input inst_type_e t);
    return (t == IT_ALU) || (t == IT_LOAD);
  endfunction
endpackage

// File: rtl/commit_ptr.sv
// Head pointer and occupancy counter with full/empty/sticky overflow; updates 1 cycle after alloc/retire.
// Allocs arriving while full are dropped and latch overflow; flush clears head/count but keeps overflow.
module commit_ptr
  import commit_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_i,
  input  logic             retire_i,
  output logic [PTR_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             alloc_ok;

  always_comb begin
    alloc_ok = alloc_i & ~full_o;
    head_d   = retire_i ? head_q + 1'b1 : head_q;
    count_d  = count_q;
    if (alloc_ok && !retire_i) begin
      count_d = count_q + 1'b1;
    end else if (!alloc_ok && retire_i) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q | (alloc_i & full_o);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head_o     = head_q;
  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign overflow_o = ovf_q;
endmodule

// File: rtl/commit_unit.sv
// In-order retirement of the temp register file head: 1-cycle latency to commit/ARF write, stores wait on st_ack.
// Head stalls while not valid/spec_valid or while a store awaits ack. Optional retired_cnt under COMMIT_STATS_EN.
module commit_unit
  import commit_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                alloc,
  output logic [PTR_W-1:0]    Rd_Addr,
  input  logic [ENTRY_W-1:0]  Data_In,
  output logic                arf_we,
  output logic [4:0]          arf_waddr,
  output logic [31:0]         arf_wdata,
  output logic                st_req,
  input  logic                st_ack,
  output logic                commit_valid,
  output logic [31:0]         commit_pc,
  output logic                full,
  output logic                empty,
  output logic                overflow
`ifdef COMMIT_STATS_EN
  , output logic [31:0]       retired_cnt
`endif
);
  state_e      state_q, state_d;
  logic        st_req_q, st_req_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cv_q, cv_d;
  logic [31:0] pc_q, pc_d;
  logic        retire;
  logic        ready;
  logic [PTR_W-1:0] head;
  inst_type_e  itype;
  logic [4:0]  rd;

  commit_ptr u_ptr (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .alloc_i    (alloc),
    .retire_i   (retire),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  assign itype = inst_type_e'(Data_In[TYPE_HI:TYPE_LO]);
  assign rd    = Data_In[RD_HI:RD_LO];
  assign ready = ~empty & Data_In[VLD_BIT] & Data_In[SPEC_VLD_BIT];

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    st_req_d = 1'b0;
    cv_d     = 1'b0;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          if (itype == IT_STORE) begin
            state_d  = ST_STORE_WAIT;
            st_req_d = 1'b1;
          end else begin
            retire = 1'b1;
            cv_d   = 1'b1;
            pc_d   = Data_In[PC_HI:PC_LO];
            if (writes_reg(itype)) begin
              // r0 is hardwired to zero, so its writes are dropped
              we_d    = (rd != 5'd0);
              waddr_d = rd;
              wdata_d = Data_In[DATA_HI:DATA_LO];
            end
          end
        end
      end
      ST_STORE_WAIT: begin
        if (st_ack) begin
          retire  = 1'b1;
          cv_d    = 1'b1;
          pc_d    = Data_In[PC_HI:PC_LO];
          state_d = ST_IDLE;
        end else begin
          st_req_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) retire = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      st_req_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cv_q     <= 1'b0;
      pc_q     <= '0;
    end else if (flush) begin
      state_q  <= ST_IDLE;
      st_req_q <= 1'b0;
      we_q     <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_req_q <= st_req_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      cv_q     <= cv_d;
      pc_q     <= pc_d;
    end
  end

`ifdef COMMIT_STATS_EN
  logic [31:0] cnt_q;
  // survives flush on purpose: counts every commit since reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cv_q) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
  assign retired_cnt = cnt_q;
`endif

  assign Rd_Addr      = head;
  assign arf_we       = we_q;
  assign arf_waddr    = waddr_q;
  assign arf_wdata    = wdata_q;
  assign st_req       = st_req_q;
  assign commit_valid = cv_q;
  assign commit_pc    = pc_q;
endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: temp-file model drives Data_In, a scoreboard checks every commit.
module tb_commit_unit;
  logic        clock = 1'b0;
  logic        reset, flush, alloc, st_ack;
  logic [4:0]  Rd_Addr;
  logic [72:0] Data_In;
  logic        arf_we, st_req, commit_valid, full, empty, overflow;
  logic [4:0]  arf_waddr;
  logic [31:0] arf_wdata, commit_pc;
`ifdef COMMIT_STATS_EN
  logic [31:0] retired_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  logic [72:0] mem [32];
  int          tests = 0;
  int          fails = 0;
  int          tail  = 0;

  always #5 clock = ~clock;
  assign Data_In = mem[Rd_Addr];

  commit_unit dut (
    .clock(clock), .reset(reset), .flush(flush), .alloc(alloc),
    .Rd_Addr(Rd_Addr), .Data_In(Data_In),
    .arf_we(arf_we), .arf_waddr(arf_waddr), .arf_wdata(arf_wdata),
    .st_req(st_req), .st_ack(st_ack),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .full(full), .empty(empty), .overflow(overflow)
`ifdef COMMIT_STATS_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  function automatic logic [72:0] mk(input logic [4:0] rd, input logic [31:0] pc,
                                     input logic [1:0] t, input logic [31:0] d,
                                     input logic sv, input logic v);
    return {rd, pc, t, d, sv, v};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_alloc(input logic [72:0] e);
    mem[tail] = e;
    alloc = 1'b1;
    tick();
    alloc = 1'b0;
    tail = (tail + 1) % 32;
  endtask

  task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.pc = pc; e.we = we; e.wa = we ? wa : 5'd0; e.wd = we ? wd : 32'd0;
    sb.push_back(e);
  endtask

  // Commit monitor: every commit_valid must match the oldest expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && commit_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_commit observed pc=%0h expected no commit", commit_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tests++;
        assert (commit_pc === e.pc && arf_we === e.we &&
                (!e.we || (arf_waddr === e.wa && arf_wdata === e.wd))) else begin
          fails++;
          $error("FAIL commit observed pc=%0h we=%0b wa=%0d wd=%0h expected pc=%0h we=%0b wa=%0d wd=%0h",
                 commit_pc, arf_we, arf_waddr, arf_wdata, e.pc, e.we, e.wa, e.wd);
        end
      end
    end
  end

  task automatic wait_empty(input string tag, input int budget);
    int n;
    n = 0;
    while ((empty !== 1'b1 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
  endtask

  initial begin
    logic [31:0] cnt0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b0; flush = 1'b0; alloc = 1'b0; st_ack = 1'b0;
    tick(); tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_outs", {48'd0, Rd_Addr, full, overflow, arf_we, st_req, commit_valid, commit_pc[4:0], arf_waddr}, 64'd0);
`ifdef COMMIT_STATS_EN
    chk("rst_cnt", 64'(retired_cnt), 64'd0);
`endif
    reset = 1'b1;
    tick();

    // Three mixed entries retire back-to-back
    push(32'h100, 1'b1, 5'd5, 32'h11);
    push(32'h104, 1'b1, 5'd6, 32'h22);
    push(32'h108, 1'b0, 5'd0, 32'h0);
    do_alloc(mk(5'd5, 32'h100, 2'b00, 32'h11, 1'b1, 1'b1));
    do_alloc(mk(5'd6, 32'h104, 2'b01, 32'h22, 1'b1, 1'b1));
    do_alloc(mk(5'd9, 32'h108, 2'b11, 32'h33, 1'b1, 1'b1));
    wait_empty("t1", 10);
    chk("t1_head", 64'(Rd_Addr), 64'd3);

    // Head waits on spec_valid
    do_alloc(mk(5'd7, 32'h200, 2'b00, 32'h77, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_stall", {62'd0, commit_valid, empty}, 64'd0);
    end
    push(32'h200, 1'b1, 5'd7, 32'h77);
    mem[3][1] = 1'b1;
    tick();
    chk("t2_commit", 64'(commit_valid), 64'd1);
    chk("t2_head", 64'(Rd_Addr), 64'd4);

    // Store with delayed ack
    push(32'h300, 1'b0, 5'd0, 32'h0);
    do_alloc(mk(5'd1, 32'h300, 2'b10, 32'hAB, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_streq", {62'd0, st_req, commit_valid}, 64'd2);
    end
    st_ack = 1'b1;
    tick();
    st_ack = 1'b0;
    chk("t3_done", {62'd0, st_req, commit_valid}, 64'd1);
    chk("t3_head", 64'(Rd_Addr), 64'd5);

    // Fill to full with stalled entries, overflow, then drain across the wrap
    for (int i = 0; i < 32; i++)
      do_alloc(mk(5'((i % 31) + 1), 32'h1000 + 32'(i * 4), 2'b00, 32'(i * 3), 1'b0, 1'b1));
    chk("t4_full", {62'd0, full, overflow}, 64'd2);
    alloc = 1'b1;
    tick();
    alloc = 1'b0;
    tick();
    chk("t4_ovf", {62'd0, full, overflow}, 64'd3);
    chk("t4_head_hold", 64'(Rd_Addr), 64'd5);
    for (int i = 0; i < 32; i++) begin
      push(32'h1000 + 32'(i * 4), 1'b1, 5'((i % 31) + 1), 32'(i * 3));
      mem[(5 + i) % 32][1] = 1'b1;
    end
    wait_empty("t4", 40);
    chk("t4_wrap_head", 64'(Rd_Addr), 64'd5);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Flush while waiting on a store, with a coincident ack
    do_alloc(mk(5'd2, 32'h400, 2'b10, 32'hCD, 1'b1, 1'b1));
    tick();
    chk("t5_streq", 64'(st_req), 64'd1);
    flush = 1'b1; st_ack = 1'b1;
    tick();
    flush = 1'b0; st_ack = 1'b0;
    chk("t5_flush", {56'd0, st_req, commit_valid, arf_we, Rd_Addr}, 64'd0);
    chk("t5_empty_ovf", {62'd0, empty, overflow}, 64'd3);
    tick();
    chk("t5_quiet", {62'd0, st_req, commit_valid}, 64'd0);
    tail = 0;

    // Write to r0 commits without an ARF write
`ifdef COMMIT_STATS_EN
    cnt0 = retired_cnt;
`else
    cnt0 = 32'd0;
`endif
    push(32'h500, 1'b0, 5'd0, 32'h0);
    do_alloc(mk(5'd0, 32'h500, 2'b00, 32'h5, 1'b1, 1'b1));
    tick();
    chk("t6_commit", {62'd0, commit_valid, arf_we}, 64'd2);
    wait_empty("t6", 5);
`ifdef COMMIT_STATS_EN
    chk("t6_cnt", 64'(retired_cnt), 64'(cnt0 + 32'd1));
`else
    chk("t6_nocnt", 64'(cnt0), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
